// File: rtl/move_stream_fifo_pkg.sv
// =============================================================================
// move_stream_fifo_pkg : shared move-word constants and field ranges
// Revision: 1.0
// =============================================================================
`default_nettype none

package move_stream_fifo_pkg;

  localparam int MV_W     = 19;
  localparam int INV_BIT  = 18;
  localparam int FLAGS_HI = 17;
  localparam int FLAGS_LO = 12;
  localparam int FROM_HI  = 11;
  localparam int FROM_LO  = 6;
  localparam int TO_HI    = 5;
  localparam int TO_LO    = 0;

  // Presented on mv_out whenever no lane is pending.
  localparam logic [MV_W-1:0] MV_NONE = 19'h40000;

endpackage

`default_nettype wire

// File: rtl/move_stream_fifo_word.sv
// =============================================================================
// move_word_fifo : circular word store with registered count and first-word
// head read-out.  Revision: 1.0
// =============================================================================
`default_nettype none

module move_word_fifo #(
  parameter int WIDTH = 152,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers are log2(DEPTH) wide, so increment wraps modulo DEPTH.
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/move_stream_fifo.sv
// =============================================================================
// move_stream_fifo : buffers packed move words and streams their valid lanes
// one per cycle in lane order.  Revision: 1.0
// =============================================================================
`default_nettype none

module move_stream_fifo
  import move_stream_fifo_pkg::*;
#(
  parameter int MV_PER_WORD = 8,
  parameter int DEPTH       = 16,
  parameter int CNT_W       = 10
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [MV_PER_WORD*MV_W-1:0] wr_data,
  output logic                        full,
  output logic [MV_W-1:0]             mv_out,
  output logic                        mv_valid,
  input  logic                        rd_ready,
  output logic                        mv_last,
  output logic                        empty,
  output logic [CNT_W-1:0]            move_count,
  output logic                        overflow
);

  localparam int WORD_W = MV_PER_WORD * MV_W;
  localparam int PC_W   = $clog2(MV_PER_WORD + 1);
  localparam int SUM_W  = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

  logic [WORD_W-1:0]      head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_push;
  logic                   load;

  logic [WORD_W-1:0]      word_q, word_d;
  logic [MV_PER_WORD-1:0] mask_q, mask_d;
  logic [MV_PER_WORD-1:0] mask_pop;
  logic [CNT_W-1:0]       move_count_q, move_count_d;
  logic                   overflow_q, overflow_d;

  logic [MV_PER_WORD-1:0] wr_valid;
  logic [MV_PER_WORD-1:0] head_valid;
  logic [MV_PER_WORD-1:0] lowest;
  logic [MV_W-1:0]        lane_mv [MV_PER_WORD];
  logic [PC_W-1:0]        wr_pop;
  logic [SUM_W-1:0]       cnt_sum;
  logic [MV_W-1:0]        sel_mv;
  logic                   wr_accept;
  logic                   lane_pop;
  logic                   mask_one;

  // Lane 0 occupies the most significant slot of a packed word.
  for (genvar i = 0; i < MV_PER_WORD; i++) begin : g_lane
    assign wr_valid[i]   = ~wr_data[(MV_PER_WORD-1-i)*MV_W + INV_BIT];
    assign head_valid[i] = ~head[(MV_PER_WORD-1-i)*MV_W + INV_BIT];
    assign lane_mv[i]    = word_q[(MV_PER_WORD-1-i)*MV_W +: MV_W];
  end

  assign wr_accept = wr_en && !fifo_full;
  assign fifo_push = wr_accept && (wr_valid != '0);

  move_word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_word_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (load),
    .din   (wr_data),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    wr_pop = '0;
    for (int i = 0; i < MV_PER_WORD; i++) begin
      wr_pop = wr_pop + PC_W'(wr_valid[i]);
    end
  end

  // Isolate the lowest set mask bit; it selects the lane on mv_out.
  assign lowest   = mask_q & (~mask_q + MV_PER_WORD'(1));
  assign mask_one = (mask_q != '0) && ((mask_q & (mask_q - MV_PER_WORD'(1))) == '0);

  always_comb begin
    sel_mv = '0;
    for (int i = 0; i < MV_PER_WORD; i++) begin
      if (lowest[i]) sel_mv = sel_mv | lane_mv[i];
    end
  end

  assign mv_valid = (mask_q != '0);
  assign lane_pop = mv_valid && rd_ready;

  // Reload on the same edge the last lane leaves, so words stream back-to-back.
  always_comb begin
    mask_pop = mask_q;
    if (lane_pop) mask_pop = mask_q & ~lowest;
    load   = (mask_pop == '0) && !fifo_empty;
    mask_d = load ? head_valid : mask_pop;
    word_d = load ? head : word_q;
  end

  always_comb begin
    cnt_sum      = {{(SUM_W-CNT_W){1'b0}}, move_count_q} + SUM_W'(wr_pop);
    move_count_d = move_count_q;
    if (wr_accept) begin
      move_count_d = (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end
    overflow_d = overflow_q || (wr_en && fifo_full);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q       <= '0;
      word_q       <= '1;
      move_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      mask_q       <= mask_d;
      word_q       <= word_d;
      move_count_q <= move_count_d;
      overflow_q   <= overflow_d;
    end
  end

  assign mv_out     = mv_valid ? sel_mv : MV_NONE;
  assign mv_last    = mv_valid && mask_one && fifo_empty && !wr_accept;
  assign empty      = fifo_empty && (mask_q == '0);
  assign full       = fifo_full;
  assign move_count = move_count_q;
  assign overflow   = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_move_stream_fifo.sv
// =============================================================================
// tb_move_stream_fifo : vector table plus directed multi-cycle sequences.
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_move_stream_fifo;
  import move_stream_fifo_pkg::*;

  localparam int MPW    = 8;
  localparam int WORD_W = MPW * MV_W;
  localparam logic [MV_W-1:0] INV = 19'h40000;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_en;
  logic [WORD_W-1:0] wr_data;
  logic              full;
  logic [MV_W-1:0]   mv_out;
  logic              mv_valid;
  logic              rd_ready;
  logic              mv_last;
  logic              empty;
  logic [9:0]        move_count;
  logic              overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  move_stream_fifo #(.MV_PER_WORD(MPW), .DEPTH(16), .CNT_W(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .mv_out     (mv_out),
    .mv_valid   (mv_valid),
    .rd_ready   (rd_ready),
    .mv_last    (mv_last),
    .empty      (empty),
    .move_count (move_count),
    .overflow   (overflow)
  );

  typedef struct {
    logic              wr_en;
    logic [WORD_W-1:0] wr_data;
    logic              rd_ready;
    logic              exp_valid;
    logic [MV_W-1:0]   exp_out;
    logic              exp_last;
    logic              exp_empty;
    logic              exp_full;
    logic [9:0]        exp_cnt;
    logic              exp_ovf;
  } vec_t;

  vec_t vecs[13];

  function automatic logic [MV_W-1:0] mk_mv(input int w, input int l);
    logic [MV_W-1:0] m;
    m = '0;
    m[FLAGS_HI:FLAGS_LO] = 6'(w);
    m[FROM_HI:FROM_LO]   = 6'(l);
    m[TO_HI:TO_LO]       = 6'(w + l);
    return m;
  endfunction

  function automatic logic [WORD_W-1:0] mk_word(input int w, input logic [MPW-1:0] vm);
    logic [WORD_W-1:0] wd;
    wd = '0;
    for (int l = 0; l < MPW; l++) begin
      wd[(MPW-1-l)*MV_W +: MV_W] = vm[l] ? mk_mv(w, l) : 19'h7FFFF;
    end
    return wd;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; wr_en = 1'b0; rd_ready = 1'b0; wr_data = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [WORD_W-1:0] w_a, w_b, w_inv;
  logic [MV_W-1:0]   sb[$];
  logic [MV_W-1:0]   held;
  bit                hold_pending;
  int                cyc;
  int                accepted;

  initial begin
    reset = 1'b1; wr_en = 1'b0; rd_ready = 1'b0; wr_data = '0;
    w_a   = mk_word(1, 8'b1000_1001);
    w_b   = mk_word(2, 8'b0000_0110);
    w_inv = mk_word(0, 8'h00);

    vecs[0]  = '{1'b1, w_inv, 1'b1, 1'b0, INV,         1'b0, 1'b1, 1'b0, 10'd0, 1'b0};
    vecs[1]  = '{1'b1, w_inv, 1'b0, 1'b0, INV,         1'b0, 1'b1, 1'b0, 10'd0, 1'b0};
    vecs[2]  = '{1'b0, w_inv, 1'b1, 1'b0, INV,         1'b0, 1'b1, 1'b0, 10'd0, 1'b0};
    vecs[3]  = '{1'b1, w_a,   1'b0, 1'b0, INV,         1'b0, 1'b1, 1'b0, 10'd0, 1'b0};
    vecs[4]  = '{1'b0, '0,    1'b0, 1'b0, INV,         1'b0, 1'b0, 1'b0, 10'd3, 1'b0};
    vecs[5]  = '{1'b0, '0,    1'b0, 1'b1, mk_mv(1, 0), 1'b0, 1'b0, 1'b0, 10'd3, 1'b0};
    vecs[6]  = '{1'b0, '0,    1'b1, 1'b1, mk_mv(1, 0), 1'b0, 1'b0, 1'b0, 10'd3, 1'b0};
    vecs[7]  = '{1'b0, '0,    1'b1, 1'b1, mk_mv(1, 3), 1'b0, 1'b0, 1'b0, 10'd3, 1'b0};
    vecs[8]  = '{1'b1, w_b,   1'b1, 1'b1, mk_mv(1, 7), 1'b0, 1'b0, 1'b0, 10'd3, 1'b0};
    vecs[9]  = '{1'b0, '0,    1'b1, 1'b0, INV,         1'b0, 1'b0, 1'b0, 10'd5, 1'b0};
    vecs[10] = '{1'b0, '0,    1'b1, 1'b1, mk_mv(2, 1), 1'b0, 1'b0, 1'b0, 10'd5, 1'b0};
    vecs[11] = '{1'b0, '0,    1'b1, 1'b1, mk_mv(2, 2), 1'b1, 1'b0, 1'b0, 10'd5, 1'b0};
    vecs[12] = '{1'b0, '0,    1'b1, 1'b0, INV,         1'b0, 1'b1, 1'b0, 10'd5, 1'b0};

    do_reset();
    #1;
    chk("rst_full", full, 0);
    chk("rst_valid", mv_valid, 0);
    chk("rst_last", mv_last, 0);
    chk("rst_empty", empty, 1);
    chk("rst_out", mv_out, INV);
    chk("rst_cnt", move_count, 0);
    chk("rst_ovf", overflow, 0);

    // Vector table: inputs driven at negedge, outputs sampled before the next edge.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      wr_en = vecs[i].wr_en; wr_data = vecs[i].wr_data; rd_ready = vecs[i].rd_ready;
      #1;
      chk($sformatf("v%0d_valid", i), mv_valid,   vecs[i].exp_valid);
      chk($sformatf("v%0d_out", i),   mv_out,     vecs[i].exp_out);
      chk($sformatf("v%0d_last", i),  mv_last,    vecs[i].exp_last);
      chk($sformatf("v%0d_empty", i), empty,      vecs[i].exp_empty);
      chk($sformatf("v%0d_full", i),  full,       vecs[i].exp_full);
      chk($sformatf("v%0d_cnt", i),   move_count, vecs[i].exp_cnt);
      chk($sformatf("v%0d_ovf", i),   overflow,   vecs[i].exp_ovf);
    end

    // Two full words back-to-back: sixteen moves with no bubble.
    do_reset();
    wr_en = 1'b1; wr_data = mk_word(1, 8'hFF); rd_ready = 1'b1;
    @(negedge clk);
    wr_data = mk_word(2, 8'hFF);
    @(negedge clk);
    wr_en = 1'b0;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk($sformatf("b2b_valid%0d", k), mv_valid, 1);
      chk($sformatf("b2b_out%0d", k), mv_out, mk_mv(1 + k / 8, k % 8));
      @(negedge clk);
    end
    #1;
    chk("b2b_done_valid", mv_valid, 0);
    chk("b2b_done_empty", empty, 1);
    chk("b2b_cnt", move_count, 16);

    // Fill with rd_ready low: 17 words fit (16 stored + 1 unpacking), 18th drops.
    do_reset();
    sb.delete();
    for (int n = 1; n <= 18; n++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_data = mk_word(n, 8'hFF);
      #1;
      if (n == 17) chk("full_before17", full, 0);
      if (n == 18) begin
        chk("full_before18", full, 1);
        chk("ovf_before18", overflow, 0);
      end
      if (n <= 17) for (int l = 0; l < MPW; l++) sb.push_back(mk_mv(n, l));
    end
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    chk("fill_full", full, 1);
    chk("fill_ovf", overflow, 1);
    chk("fill_cnt", move_count, 136);

    // Random-stall drain against the scoreboard.
    hold_pending = 1'b0;
    cyc = 0;
    while (sb.size() != 0 && cyc < 3000) begin
      @(negedge clk);
      rd_ready = 1'($urandom_range(0, 1));
      #1;
      cyc++;
      if (mv_valid) begin
        if (hold_pending) chk("stall_stable", mv_out, held);
        if (rd_ready) begin
          chk("drain_order", mv_out, sb[0]);
          void'(sb.pop_front());
          hold_pending = 1'b0;
        end else begin
          held = mv_out;
          hold_pending = 1'b1;
        end
      end else begin
        hold_pending = 1'b0;
      end
    end
    chk("drain_left", sb.size(), 0);
    @(negedge clk);
    rd_ready = 1'b0;
    #1;
    chk("drain_empty", empty, 1);
    chk("drain_ovf_sticky", overflow, 1);

    // Reset in the middle of a stream, with a write on the reset cycle.
    @(negedge clk);
    wr_en = 1'b1; wr_data = mk_word(1, 8'hFF);
    @(negedge clk);
    wr_data = mk_word(2, 8'hFF);
    @(negedge clk);
    wr_en = 1'b0; rd_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_valid", mv_valid, 1);
    @(negedge clk);
    reset = 1'b1; wr_en = 1'b1; wr_data = mk_word(3, 8'hFF);
    @(negedge clk);
    reset = 1'b0; wr_en = 1'b0; rd_ready = 1'b0;
    #1;
    chk("mrst_empty", empty, 1);
    chk("mrst_cnt", move_count, 0);
    chk("mrst_ovf", overflow, 0);
    chk("mrst_valid", mv_valid, 0);
    chk("mrst_out", mv_out, INV);
    @(negedge clk);
    #1;
    chk("mrst_empty2", empty, 1);

    // Counter saturation: 130 full words exceed 1023 moves.
    accepted = 0;
    cyc = 0;
    rd_ready = 1'b1;
    while (accepted < 130 && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      if (!full) begin
        wr_en = 1'b1; wr_data = mk_word(accepted % 60, 8'hFF);
        accepted++;
      end else begin
        wr_en = 1'b0;
      end
    end
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    chk("sat_accepted", accepted, 130);
    chk("sat_cnt", move_count, 1023);
    chk("sat_ovf", overflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
